matrix_exec_unit: RTL

Sequencing execution stage that sits directly upstream of the matrix memory on the shared 256-bit `dataBus`. It accepts one matrix instruction at a time (opcode, two source addresses, one destination address), reads operands from memory over the bus, computes the result, and writes it back. Matrices are 4x4 of 16-bit elements, 256 bits total. Element (r,c) occupies bits [16*(4r+c) +: 16].

---
 rtl/matrix_pkg.sv | 29 ++
 rtl/matrix_datapath.sv | 47 ++++
 rtl/matrix_exec_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, opcodes, FSM states and element indexing for the matrix execution unit
package matrix_pkg;

    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int MAT_W  = ELEM_W * DIM * DIM;

    localparam logic [3:0] OP_ADD       = 4'd0;
    localparam logic [3:0] OP_SUB       = 4'd1;
    localparam logic [3:0] OP_TRANSPOSE = 4'd2;
    localparam logic [3:0] OP_MUL       = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDA_REQ,
        ST_RDA_CAP,
        ST_RDB_REQ,
        ST_RDB_CAP,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } execStateT;

    // Bit offset of element (r,c) inside a packed 4x4 matrix word.
    function automatic int elemOffset(input int r, input int c);
        return ELEM_W * (DIM * r + c);
    endfunction

endpackage

// File: rtl/matrix_datapath.sv
// rtl/matrix_datapath.sv - element-wise ADD/SUB, TRANSPOSE and, under MATRIX_MUL_EN, one MUL element per index k
module matrix_datapath
    import matrix_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [MAT_W-1:0]  opA,
    input  logic [MAT_W-1:0]  opB,
    output logic [MAT_W-1:0]  result
`ifdef MATRIX_MUL_EN
    ,
    input  logic [3:0]        k,
    output logic [ELEM_W-1:0] mulElem
`endif
);

    always_comb begin
        result = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                case (opcode)
                    OP_ADD:       result[elemOffset(r, c) +: ELEM_W] = opA[elemOffset(r, c) +: ELEM_W] + opB[elemOffset(r, c) +: ELEM_W];
                    OP_SUB:       result[elemOffset(r, c) +: ELEM_W] = opA[elemOffset(r, c) +: ELEM_W] - opB[elemOffset(r, c) +: ELEM_W];
                    OP_TRANSPOSE: result[elemOffset(r, c) +: ELEM_W] = opA[elemOffset(c, r) +: ELEM_W];
                    default:      ;
                endcase
            end
        end
    end

`ifdef MATRIX_MUL_EN
    logic [ELEM_W-1:0] elemA;
    logic [ELEM_W-1:0] elemB;

    // Row k[3:2] of A dotted with column k[1:0] of B; truncating 16x16 keeps only the low product bits.
    always_comb begin
        mulElem = '0;
        elemA   = '0;
        elemB   = '0;
        for (int i = 0; i < DIM; i++) begin
            elemA   = opA[elemOffset(int'(k[3:2]), i) +: ELEM_W];
            elemB   = opB[elemOffset(i, int'(k[1:0])) +: ELEM_W];
            mulElem = mulElem + elemA * elemB;
        end
    end
`endif

endmodule

// File: rtl/matrix_exec_unit.sv
// rtl/matrix_exec_unit.sv - matrix instruction sequencer: reads operands over dataBus, executes, writes back (MUL under MATRIX_MUL_EN)
module matrix_exec_unit #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic                      start,
    input  logic [3:0]                opcode,
    input  logic [7:0]                srcA,
    input  logic [7:0]                srcB,
    input  logic [7:0]                dest,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [7:0]                address,
    output logic                      nMatrixMemEnable,
    output logic                      ReadnWrite,
    inout  wire  [ELEM_W*DIM*DIM-1:0] dataBus
);
    import matrix_pkg::*;

    localparam int MAT_BITS = ELEM_W * DIM * DIM;

    execStateT           state;
    logic [3:0]          opReg;
    logic [7:0]          addrB;
    logic [7:0]          addrDest;
    logic [MAT_BITS-1:0] opA;
    logic [MAT_BITS-1:0] opB;
    logic [MAT_BITS-1:0] resultReg;
    logic [MAT_BITS-1:0] dpResult;
    logic                opLegal;
    logic                execLast;

`ifdef MATRIX_MUL_EN
    logic [3:0]          mulK;
    logic [ELEM_W-1:0]   mulElem;

    always_comb begin
        opLegal  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_TRANSPOSE) || (opcode == OP_MUL);
        execLast = (opReg != OP_MUL) || (mulK == 4'd15);
    end

    matrix_datapath uDatapath (
        .opcode  (opReg),
        .opA     (opA),
        .opB     (opB),
        .result  (dpResult),
        .k       (mulK),
        .mulElem (mulElem)
    );
`else
    always_comb begin
        opLegal  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_TRANSPOSE);
        execLast = 1'b1;
    end

    matrix_datapath uDatapath (
        .opcode (opReg),
        .opA    (opA),
        .opB    (opB),
        .result (dpResult)
    );
`endif

    assign dataBus = (!nMatrixMemEnable && !ReadnWrite) ? resultReg : {MAT_BITS{1'bz}};

    // Bus controls are registered on the transition into each state so they are valid for that whole cycle.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state            <= ST_IDLE;
            opReg            <= '0;
            addrB            <= '0;
            addrDest         <= '0;
            opA              <= '0;
            opB              <= '0;
            resultReg        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            address          <= '0;
            nMatrixMemEnable <= 1'b1;
            ReadnWrite       <= 1'b1;
`ifdef MATRIX_MUL_EN
            mulK             <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opReg    <= opcode;
                        addrB    <= srcB;
                        addrDest <= dest;
                        busy     <= 1'b1;
`ifdef MATRIX_MUL_EN
                        mulK     <= '0;
`endif
                        if (opLegal) begin
                            state            <= ST_RDA_REQ;
                            address          <= srcA;
                            nMatrixMemEnable <= 1'b0;
                            ReadnWrite       <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    end
                end
                ST_RDA_REQ: state <= ST_RDA_CAP;
                ST_RDA_CAP: begin
                    opA <= dataBus;
                    if (opReg == OP_TRANSPOSE) begin
                        state            <= ST_EXEC;
                        nMatrixMemEnable <= 1'b1;
                    end else begin
                        state   <= ST_RDB_REQ;
                        address <= addrB;
                    end
                end
                ST_RDB_REQ: state <= ST_RDB_CAP;
                ST_RDB_CAP: begin
                    opB              <= dataBus;
                    state            <= ST_EXEC;
                    nMatrixMemEnable <= 1'b1;
                end
                ST_EXEC: begin
`ifdef MATRIX_MUL_EN
                    if (opReg == OP_MUL) begin
                        resultReg[int'(mulK) * ELEM_W +: ELEM_W] <= mulElem;
                        mulK <= mulK + 4'd1;
                    end else begin
                        resultReg <= dpResult;
                    end
`else
                    resultReg <= dpResult;
`endif
                    if (execLast) begin
                        state            <= ST_WRITE;
                        address          <= addrDest;
                        nMatrixMemEnable <= 1'b0;
                        ReadnWrite       <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state            <= ST_DONE;
                    nMatrixMemEnable <= 1'b1;
                    ReadnWrite       <= 1'b1;
                    done             <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
